// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU + ALU control decoder between the execute
// stage (requester 0) and the AXI4-lite test/accelerator port (requester 1).
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [1:0]      r0_aluop,
    input  logic [6:0]      r0_funct7,
    input  logic [2:0]      r0_funct3,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [1:0]      r1_aluop,
    input  logic [6:0]      r1_funct7,
    input  logic [2:0]      r1_funct3,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    output logic [1:0]      alu_aluop,
    output logic [6:0]      alu_funct7,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [4:0]      alu_ctrl_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_flag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_flag,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [4:0] CTRL_ILLEGAL = 5'b11111;

    state_t state, state_nx;
    logic   last_grant;
    logic   pending_id;
    logic   winner;
    logic   handshake;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        winner = 1'b0;
        if (r0_valid && r1_valid)
            winner = ~last_grant;
        else if (r1_valid)
            winner = 1'b1;
    end

    assign r0_ready  = (state == IDLE) && r0_valid && !winner;
    assign r1_ready  = (state == IDLE) && r1_valid &&  winner;
    assign handshake = r0_ready | r1_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (handshake) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            pending_id  <= 1'b0;
            alu_aluop   <= '0;
            alu_funct7  <= '0;
            alu_funct3  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flag    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            state <= state_nx;

            if (handshake) begin
                last_grant <= winner;
                pending_id <= winner;
                alu_aluop  <= winner ? r1_aluop  : r0_aluop;
                alu_funct7 <= winner ? r1_funct7 : r0_funct7;
                alu_funct3 <= winner ? r1_funct3 : r0_funct3;
                alu_a      <= winner ? r1_a      : r0_a;
                alu_b      <= winner ? r1_b      : r0_b;
            end

            // The ALU path is combinational, so one EXEC cycle settles the result.
            if (state == EXEC) begin
                rsp_valid   <= 1'b1;
                rsp_id      <= pending_id;
                rsp_result  <= alu_result;
                rsp_flag    <= alu_flag;
                rsp_illegal <= (alu_ctrl_op == CTRL_ILLEGAL);
            end

            if (state == RESP && rsp_ready)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU/decoder stub sits on the
// alu_* port and a scoreboard queue holds the expected responses.
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            id;
        logic [XLEN-1:0] result;
        logic            flag;
        logic            illegal;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            r0_valid, r0_ready, r1_valid, r1_ready;
    logic [1:0]      r0_aluop, r1_aluop;
    logic [6:0]      r0_funct7, r1_funct7;
    logic [2:0]      r0_funct3, r1_funct3;
    logic [XLEN-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [1:0]      alu_aluop;
    logic [6:0]      alu_funct7;
    logic [2:0]      alu_funct3;
    logic [XLEN-1:0] alu_a, alu_b;
    logic [4:0]      alu_ctrl_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_flag;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_flag, rsp_illegal;
    logic [XLEN-1:0] rsp_result;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_aluop(r0_aluop),
        .r0_funct7(r0_funct7), .r0_funct3(r0_funct3), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_aluop(r1_aluop),
        .r1_funct7(r1_funct7), .r1_funct3(r1_funct3), .r1_a(r1_a), .r1_b(r1_b),
        .alu_aluop(alu_aluop), .alu_funct7(alu_funct7), .alu_funct3(alu_funct3),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl_op(alu_ctrl_op),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_illegal(rsp_illegal)
    );

    // Stand-in decoder + ALU: add/sub/xor/or/and plus beq; anything else is illegal.
    always_comb begin
        alu_ctrl_op = 5'b11111;
        alu_result  = 32'hDEAD_BEEF;
        alu_flag    = (alu_a == alu_b);
        case (alu_aluop)
            2'b00: begin alu_ctrl_op = 5'd0; alu_result = alu_a + alu_b; end
            2'b01: begin alu_ctrl_op = 5'd1; alu_result = alu_a - alu_b; end
            2'b10: begin
                if (alu_funct3 == 3'b000 && alu_funct7 == 7'b0000000) begin
                    alu_ctrl_op = 5'd0; alu_result = alu_a + alu_b;
                end else if (alu_funct3 == 3'b000 && alu_funct7 == 7'b0100000) begin
                    alu_ctrl_op = 5'd1; alu_result = alu_a - alu_b;
                end else if (alu_funct3 == 3'b100 && alu_funct7 == 7'b0000000) begin
                    alu_ctrl_op = 5'd2; alu_result = alu_a ^ alu_b;
                end else if (alu_funct3 == 3'b110 && alu_funct7 == 7'b0000000) begin
                    alu_ctrl_op = 5'd3; alu_result = alu_a | alu_b;
                end else if (alu_funct3 == 3'b111 && alu_funct7 == 7'b0000000) begin
                    alu_ctrl_op = 5'd4; alu_result = alu_a & alu_b;
                end
            end
            2'b11: if (alu_funct3 == 3'b000) begin alu_ctrl_op = 5'd1; alu_result = alu_a - alu_b; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic idx, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (idx == 1'b0) begin
            r0_valid = 1'b1; r0_aluop = op; r0_funct7 = f7; r0_funct3 = f3; r0_a = a; r0_b = b;
        end else begin
            r1_valid = 1'b1; r1_aluop = op; r1_funct7 = f7; r1_funct3 = f3; r1_a = a; r1_b = b;
        end
    endtask

    task automatic push(input logic id, input logic [XLEN-1:0] res, input logic flag, input logic ill);
        exp_t e;
        e.id = id; e.result = res; e.flag = flag; e.illegal = ill;
        sb.push_back(e);
    endtask

    // Called at a negedge; waits (bounded) for rsp_valid, then checks against the queue head.
    task automatic expect_rsp(input string tag, input int budget);
        exp_t e;
        for (int i = 0; i < budget && !rsp_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"},      {31'd0, rsp_id},      {31'd0, e.id});
            chk({tag, "_result"},  rsp_result,           e.result);
            chk({tag, "_flag"},    {31'd0, rsp_flag},    {31'd0, e.flag});
            chk({tag, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, e.illegal});
        end
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        r0_valid = 0; r0_aluop = 0; r0_funct7 = 0; r0_funct3 = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_aluop = 0; r1_funct7 = 0; r1_funct3 = 0; r1_a = 0; r1_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ops", {20'd0, alu_aluop, alu_funct7, alu_funct3}, 32'd0);
        chk("rst_readys", {30'd0, r0_ready, r1_ready}, 32'd0);

        // Tie after reset: r0 sub wins, then r1 xor.
        drive(1'b0, 2'b10, 7'b0100000, 3'b000, 32'd9, 32'd4);
        drive(1'b1, 2'b10, 7'b0000000, 3'b100, 32'h0000_00F0, 32'h0000_000F);
        push(1'b0, 32'd5, 1'b0, 1'b0);
        push(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
        #1 chk("tie_readys", {30'd0, r0_ready, r1_ready}, 32'b10);
        @(negedge clk);
        r0_valid = 1'b0;
        chk("tie_exec_r1_ready", {31'd0, r1_ready}, 32'd0);
        expect_rsp("tie_r0", 4);
        @(negedge clk);
        chk("tie_r1_granted", {30'd0, r0_ready, r1_ready}, 32'b01);
        @(negedge clk);
        r1_valid = 1'b0;
        expect_rsp("tie_r1", 4);
        @(negedge clk);

        // Single r0 add; exact T+2 latency; operand changes after handshake ignored.
        drive(1'b0, 2'b10, 7'b0000000, 3'b000, 32'd5, 32'd7);
        push(1'b0, 32'd12, 1'b0, 1'b0);
        #1 chk("single_r0_ready", {31'd0, r0_ready}, 32'd1);
        @(negedge clk);
        r0_valid = 1'b0; r0_a = 32'd99; r0_b = 32'd1;
        chk("single_exec_ready", {31'd0, r0_ready}, 32'd0);
        chk("single_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        @(negedge clk);
        expect_rsp("single", 1);
        @(negedge clk);
        chk("single_back_idle", {31'd0, rsp_valid}, 32'd0);

        // Illegal decode completes normally; the next request is handled as usual.
        drive(1'b0, 2'b10, 7'b0100000, 3'b111, 32'd1, 32'd2);
        push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        @(negedge clk);
        r0_valid = 1'b0;
        expect_rsp("illegal", 4);
        @(negedge clk);
        drive(1'b1, 2'b10, 7'b0000000, 3'b110, 32'h30, 32'h03);
        push(1'b1, 32'h33, 1'b0, 1'b0);
        @(negedge clk);
        r1_valid = 1'b0;
        expect_rsp("after_illegal", 4);
        @(negedge clk);

        // Backpressure: r1 beq held in RESP for 4 cycles while r0 keeps asking.
        rsp_ready = 1'b0;
        drive(1'b1, 2'b11, 7'b0000000, 3'b000, 32'd3, 32'd3);
        push(1'b1, 32'd0, 1'b1, 1'b0);
        #1 chk("bp_r1_ready", {31'd0, r1_ready}, 32'd1);
        @(negedge clk);
        r1_valid = 1'b0;
        drive(1'b0, 2'b10, 7'b0000000, 3'b000, 32'd1, 32'd1);
        expect_rsp("bp", 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_hold%0d_result", i), rsp_result, 32'd0);
            chk($sformatf("bp_hold%0d_id_flag", i), {30'd0, rsp_id, rsp_flag}, 32'b11);
            chk($sformatf("bp_hold%0d_readys", i), {30'd0, r0_ready, r1_ready}, 32'b00);
            chk($sformatf("bp_hold%0d_alu_a", i), alu_a, 32'd3);
        end
        r0_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);

        // Fairness: both valid continuously, grants must alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b10, 7'b0000000, 3'b000, 32'(i * 3), 32'd1);
            drive(1'b1, 2'b10, 7'b0000000, 3'b100, 32'(i), 32'hFF);
            if (i % 2 == 0) push(1'b0, 32'(i * 3 + 1), 1'b0, 1'b0);
            else            push(1'b1, 32'(i) ^ 32'hFF, 1'b0, 1'b0);
            #1 chk($sformatf("fair%0d_readys", i), {30'd0, r0_ready, r1_ready},
                   (i % 2 == 0) ? 32'b10 : 32'b01);
            @(negedge clk);
            expect_rsp($sformatf("fair%0d", i), 4);
            @(negedge clk);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Reset during EXEC discards the transaction; a following tie goes to r0.
        drive(1'b1, 2'b10, 7'b0000000, 3'b000, 32'd2, 32'd2);
        #1 chk("rst_exec_grant", {31'd0, r1_ready}, 32'd1);
        @(negedge clk);
        r1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_exec_alu_a", alu_a, 32'd0);
        chk("rst_exec_rsp", {31'd0, rsp_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_exec_quiet%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        drive(1'b0, 2'b10, 7'b0000000, 3'b111, 32'hF0F0, 32'h0FF0);
        drive(1'b1, 2'b10, 7'b0000000, 3'b110, 32'd0, 32'd0);
        push(1'b0, 32'h00F0, 1'b0, 1'b0);
        #1 chk("rst_tie_readys", {30'd0, r0_ready, r1_ready}, 32'b10);
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0;
        expect_rsp("rst_tie", 4);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
